// File: rtl/sobel_window_gen.sv
// sobel_window_gen
// This module turns a raster-order pixel stream into 3x3 windows for the Sobel
// kernel. Two line buffers hold the previous two rows. A 3x3 register window
// shifts left by one column for every accepted pixel. A window is flagged
// valid only when all nine taps come from the same frame and the same three
// rows, so stale or wrapped data never appears with valid_out high.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     pixel_in,
  output logic                  valid_out,
  output logic [9*DATA_W-1:0]   window,
  output logic                  frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;

  // lb0 holds row r-1 and lb1 holds row r-2. Their contents are never
  // reset; the row/col gating keeps stale entries out of valid windows.
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];

  logic [DATA_W-1:0] win_p0 [3][3];
  logic              vld_p0;
  logic              done_p0;

  logic [DATA_W-1:0] col_top;
  logic [DATA_W-1:0] col_mid;
  logic              last_col;
  logic              last_row;
  logic              win_ok;

  // The line buffers are read at the current column before this cycle's
  // write, so the new column is {row r-2, row r-1, incoming pixel}.
  assign col_top  = lb1[col];
  assign col_mid  = lb0[col];
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);
  assign win_ok   = (row >= ROW_TWO) && (col >= COL_TWO);

  // Line-buffer update: push the current column down by one row.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pixel_in;
    end
  end

  // ---- stage p0: raster counters, window shift, registered flags ----
  // Counters, window and flags. On idle cycles everything holds except
  // the flags, which drop to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      vld_p0  <= 1'b0;
      done_p0 <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_p0[i][j] <= '0;
        end
      end
    end else begin
      vld_p0  <= valid_in && win_ok;
      done_p0 <= valid_in && last_col && last_row;
      if (valid_in) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
          win_p0[i][0] <= win_p0[i][1];
          win_p0[i][1] <= win_p0[i][2];
        end
        win_p0[0][2] <= col_top;
        win_p0[1][2] <= col_mid;
        win_p0[2][2] <= pixel_in;
      end
    end
  end

  // Pack the window. Row 0 is the oldest row and column 0 is the leftmost
  // column; both sit at the least significant end of the bus.
  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign window[DATA_W*(3*gi+gj) +: DATA_W] = win_p0[gi][gj];
    end
  end

  assign valid_out  = vld_p0;
  assign frame_done = done_p0;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Testbench for sobel_window_gen. Instance A is 4x4 and receives directed
// frames followed by random ones. Instance B is 5x3 and receives random
// pixels with random bubbles. A frame-level reference model predicts every
// window from a stored image of the current frame.
module tb_sobel_window_gen;

  localparam int DW = 8;
  localparam int AW = 4, AH = 4;
  localparam int BW = 5, BH = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in_a = 1'b0, valid_in_b = 1'b0;
  logic [DW-1:0] pixel_in_a = '0, pixel_in_b = '0;
  logic          valid_out_a, valid_out_b, frame_done_a, frame_done_b;
  logic [9*DW-1:0] window_a, window_b;

  int checks = 0;
  int failures = 0;

  // Reference-model state, one slot per instance.
  int          mr [2];
  int          mc [2];
  logic [7:0]  img [2][8][8];
  logic        e_vld [2];
  logic        e_done [2];
  logic        hold_ok [2];
  logic [71:0] e_win [2];
  int          act_cnt [2];

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH), .DATA_W(DW)) dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in_a), .pixel_in(pixel_in_a),
    .valid_out(valid_out_a), .window(window_a), .frame_done(frame_done_a));

  sobel_window_gen #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .DATA_W(DW)) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_in_b), .pixel_in(pixel_in_b),
    .valid_out(valid_out_b), .window(window_b), .frame_done(frame_done_b));

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // Predict what the DUT shows after the coming edge.
  task automatic model_pre(input int k, input logic v, input logic [7:0] p,
                           input int w, input int h, input logic r);
    if (r) begin
      mr[k] = 0; mc[k] = 0;
      e_vld[k] = 1'b0; e_done[k] = 1'b0;
      e_win[k] = '0; hold_ok[k] = 1'b1; act_cnt[k] = 0;
    end else if (v) begin
      img[k][mr[k]][mc[k]] = p;
      e_vld[k]  = (mr[k] >= 2) && (mc[k] >= 2);
      e_done[k] = (mr[k] == h-1) && (mc[k] == w-1);
      if (e_vld[k]) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e_win[k][8*(3*i+j) +: 8] = img[k][mr[k]-2+i][mc[k]-2+j];
        hold_ok[k] = 1'b1;
      end else begin
        hold_ok[k] = 1'b0;
      end
      mc[k]++;
      if (mc[k] == w) begin
        mc[k] = 0;
        mr[k] = (mr[k] == h-1) ? 0 : mr[k] + 1;
      end
    end else begin
      e_vld[k] = 1'b0;
      e_done[k] = 1'b0;
    end
  endtask

  task automatic model_check(input int k, input string nm, input logic vo,
                             input logic [71:0] win, input logic fd,
                             input int w, input int h);
    check({nm, ".valid_out"}, 72'(vo), 72'(e_vld[k]));
    check({nm, ".frame_done"}, 72'(fd), 72'(e_done[k]));
    if (hold_ok[k]) check({nm, ".window"}, win, e_win[k]);
    if (vo) act_cnt[k]++;
    if (e_done[k]) begin
      check({nm, ".windows_per_frame"}, 72'(act_cnt[k]), 72'((h-2)*(w-2)));
      act_cnt[k] = 0;
    end
  endtask

  // Drive one cycle on A (B gets random traffic) and check both instances.
  task automatic step(input logic va, input logic [7:0] pa);
    valid_in_a = va;
    pixel_in_a = pa;
    valid_in_b = ($urandom_range(0, 3) != 0);
    pixel_in_b = 8'($urandom);
    model_pre(0, valid_in_a, pixel_in_a, AW, AH, rst);
    model_pre(1, valid_in_b, pixel_in_b, BW, BH, rst);
    @(posedge clk);
    #1;
    model_check(0, "a", valid_out_a, window_a, frame_done_a, AW, AH);
    model_check(1, "b", valid_out_b, window_b, frame_done_b, BW, BH);
  endtask

  initial begin
    logic [7:0] px;
    // Reset with valid_in high: reset must take priority.
    rst = 1'b1;
    step(1'b1, 8'h55);
    step(1'b0, 8'h00);
    rst = 1'b0;
    step(1'b0, 8'h00);

    // Frame 1: pixel = 16*r+c, no bubbles.
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) begin
        step(1'b1, 8'(16*r + c));
        if (r == 2 && c == 2) begin
          check("a.first_valid", 72'(valid_out_a), 72'(1));
          check("a.first_window", window_a, 72'h22_21_20_12_11_10_02_01_00);
        end
        if (r == AH-1 && c == AW-1) begin
          check("a.done_pulse", 72'(frame_done_a), 72'(1));
          check("a.done_window_tail", 72'(window_a[71:64]), 72'h33);
        end
      end
    step(1'b0, 8'h00);

    // Frame 2: the same image with a bubble after every pixel.
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) begin
        step(1'b1, 8'(16*r + c));
        step(1'b0, 8'($urandom));
      end

    // Frame 3 follows immediately: pixel = 0x80 + 16*r + c.
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) begin
        step(1'b1, 8'(8'h80 + 16*r + c));
        if (r == 2 && c == 2)
          check("a.frame2_first_window", window_a, 72'hA2_A1_A0_92_91_90_82_81_80);
      end

    // Reset mid-frame after pixel (2,1), then a fresh random frame.
    for (int n = 0; n < 2*AW + 2; n++) step(1'b1, 8'($urandom));
    rst = 1'b1;
    step(1'b1, 8'($urandom));
    step(1'b1, 8'($urandom));
    rst = 1'b0;
    check("a.after_reset_window", window_a, 72'h0);
    for (int n = 0; n < AW*AH; n++) step(1'b1, 8'($urandom));

    // Random frames with random bubbles.
    for (int n = 0; n < 4*AW*AH; ) begin
      logic v;
      v  = ($urandom_range(0, 2) != 0);
      px = 8'($urandom);
      step(v, px);
      if (v) n++;
    end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Upstream neighbour of the Sobel stage: converts a raster-order pixel stream into 3x3 pixel windows for the Sobel kernel.
- Holds two line buffers (previous two rows) plus a 3x3 shift-register window.
- Emits a valid window only where all nine pixels lie inside the same frame and the same three rows, with no row wrap.
- No backpressure; consumer is always ready.

Parameters:
- IMG_WIDTH, 640, pixels per row (>= 3)
- IMG_HEIGHT, 480, rows per frame (>= 3)
- DATA_W, 8, bits per pixel

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  pixel_in valid this cycle (pixel accepted)
- pixel_in  in  DATA_W  raster-order pixel, row-major, frame after frame
- valid_out  out  1  window bus holds a complete in-frame 3x3 window
- window  out  9*DATA_W  packed window; window[DATA_W*(3*i+j) +: DATA_W] = row i (0 = oldest row), column j (0 = leftmost)
- frame_done  out  1  one-cycle pulse, cycle after the last pixel of a frame is accepted

Behaviour:
- Reset: col=0, row=0, valid_out=0, window=0, frame_done=0. Line-buffer contents are not reset; validity gating makes them irrelevant.
- Reset mid-frame: counters return to 0; the next accepted pixel is treated as (row 0, col 0); no valid_out until (2,2) of that new frame.
- Accepted pixel at position (r,c):
  - New column = {lb1[c] (row r-2), lb0[c] (row r-1), pixel_in}.
  - Line-buffer update: lb1[c] <= lb0[c]; lb0[c] <= pixel_in.
  - Reads at index c return the pre-write value (read-before-write).
  - Window shift, per row i: w[i][0] <= w[i][1]; w[i][1] <= w[i][2]; w[i][2] <= new column element i.
- Counters:
  - col increments per accepted pixel; wraps IMG_WIDTH-1 -> 0.
  - row increments on col wrap; wraps IMG_HEIGHT-1 -> 0 at end of frame.
  - Counter widths are clog2 of the respective parameter.
- valid_out (registered): 1 in the cycle after an accepted pixel with r >= 2 and c >= 2; 0 otherwise, including every cycle after valid_in=0.
  - Latency: 1 clock from accepted pixel to window/valid_out.
  - Window centre = (r-1, c-1).
- Idle cycles (valid_in=0): counters, line buffers and window hold; valid_out=0; window bus keeps its last value.
- Row boundary: pixels at c=0 and c=1 shift the window but never assert valid_out, because the window spans the previous row's tail.
- Frame boundary:
  - Rows 0 and 1 of a new frame never assert valid_out.
  - Stale previous-frame line-buffer data is never exposed in a valid window.
- frame_done = 1 in the cycle after accepting (IMG_HEIGHT-1, IMG_WIDTH-1); coincides with the last valid_out of the frame.
- Valid windows per frame: exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- Line buffers: two arrays of IMG_WIDTH x DATA_W; no arithmetic on pixel data.

Test Plan:
- Smoke window
  - Stimulus: IMG_WIDTH=4, IMG_HEIGHT=4, pixel=16*r+c, valid_in held high.
  - Response: first valid_out one cycle after the 11th pixel (2,2); window j-order row0..row2 = 00,01,02,10,11,12,20,21,22 (hex).
- Full-frame count
  - Stimulus: same stream.
  - Response: exactly 4 valid windows, centres (1,1),(1,2),(2,1),(2,2); frame_done pulses once, with the window ending in 33 (hex).
- Bubbles
  - Stimulus: same frame, valid_in toggled 1/0 every cycle.
  - Response: identical window sequence; valid_out never high in a cycle following valid_in=0.
- Back-to-back frames
  - Stimulus: two frames; second frame pixel = 0x80 + 16*r + c.
  - Response: no valid_out during frame-2 rows 0-1; first frame-2 window = 80,81,82,90,91,92,A0,A1,A2.
- Reset mid-frame
  - Stimulus: assert rst after pixel (2,1); restart the frame.
  - Response: valid_out=0, window=0 during and after reset; next valid only after new (2,2); contents match the fresh frame.
- Non-square size
  - Stimulus: IMG_WIDTH=5, IMG_HEIGHT=3.
  - Response: exactly 3 valid windows, all from row 2; none at c=0 or c=1.
